// File: rtl/slu_pkg.sv
// +-------------------------------------------------------------------+
// | slu_pkg: shared types and defaults for serial_logic_unit (rev 1.0) |
// +-------------------------------------------------------------------+
`default_nettype none

package slu_pkg;

  localparam int SLU_DEF_WIDTH = 32;
  localparam int SLU_DEF_DIGIT = 4;

  typedef enum logic [2:0] {
    OP_NAND = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/slu_digit.sv
// +-------------------------------------------------------------------+
// | slu_digit: combinational DIGIT-bit logic cell (rev 1.0)            |
// +-------------------------------------------------------------------+
`default_nettype none

module slu_digit
  import slu_pkg::*;
#(
  parameter int DIGIT = SLU_DEF_DIGIT
) (
  input  logic [2:0]       op,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic [DIGIT-1:0] y
);

  // Reserved opcodes fall through to an all-zero digit.
  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_NAND: y = ~(a & b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_logic_unit.sv
// +-------------------------------------------------------------------+
// | serial_logic_unit: digit-serial bitwise logic unit (rev 1.0)       |
// | Optional zero-result flag port enabled by SLU_ZERO_FLAG_EN.        |
// +-------------------------------------------------------------------+
`default_nettype none

module serial_logic_unit
  import slu_pkg::*;
#(
  parameter int WIDTH = SLU_DEF_WIDTH,
  parameter int DIGIT = SLU_DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic             busy
`ifdef SLU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_DIGITS - 1);

  state_e           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [DIGIT-1:0] w_y;
  logic [WIDTH-1:0] w_res_next;

  slu_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .op (r_op),
    .a  (r_a[DIGIT-1:0]),
    .b  (r_b[DIGIT-1:0]),
    .y  (w_y)
  );

  // Each new digit enters at the top so the first one lands at bit 0 when done.
  generate
    if (NUM_DIGITS == 1) begin : g_single
      assign w_res_next = w_y;
    end else begin : g_multi
      assign w_res_next = {w_y, r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_a     <= in1;
            r_b     <= in2;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out1      = out_valid ? r_res : '0;

`ifdef SLU_ZERO_FLAG_EN
  assign zero = out_valid && (r_res == '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_logic_unit.sv
// +-------------------------------------------------------------------+
// | tb_serial_logic_unit: self-checking bench for serial_logic_unit    |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_serial_logic_unit;

  localparam int W = 32;
  localparam int D = 4;
  localparam int LAT = W / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out1;
  logic         busy;
`ifdef SLU_ZERO_FLAG_EN
  logic         zero;
`endif

  int total = 0;
  int bad   = 0;

  serial_logic_unit #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .busy      (busy)
`ifdef SLU_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  // Whole-word reference: the result is just the bitwise operation on the full operands.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      3'd0:    return ~(a & b);
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"},  W'(in_ready),  W'(1));
    check({tag, " out_valid"}, W'(out_valid), W'(0));
    check({tag, " busy"},      W'(busy),      W'(0));
    check({tag, " out1"},      out1,          '0);
`ifdef SLU_ZERO_FLAG_EN
    check({tag, " zero"},      W'(zero),      W'(0));
`endif
  endtask

  // Accepts one operand set, scrambles the inputs (with in_valid high) while the
  // operation is in flight, stalls the consumer, then completes the handshake.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    logic [W-1:0] exp;
    int lat;
    exp = model(o, a, b);
    check({tag, " ready_before"}, W'(in_ready), W'(1));
    in_valid = 1'b1; op = o; in1 = a; in2 = b; out_ready = 1'b0;
    tick();
    lat = 0;
    do begin
      in1 = $urandom; in2 = $urandom; op = 3'($urandom);
      if (lat == 0) begin
        check({tag, " run_ready"}, W'(in_ready), W'(0));
        check({tag, " run_busy"},  W'(busy),     W'(1));
        check({tag, " run_out1"},  out1,         '0);
      end
      tick();
      lat++;
    end while (!out_valid && lat < 3 * LAT);
    check({tag, " latency"}, W'(lat), W'(LAT));
    for (int i = 0; i <= stall; i++) begin
      check({tag, " out1"},       out1,          exp);
      check({tag, " done_ready"}, W'(in_ready),  W'(0));
      check({tag, " done_busy"},  W'(busy),      W'(1));
`ifdef SLU_ZERO_FLAG_EN
      check({tag, " zero"},       W'(zero),      W'(exp == '0));
`endif
      if (i < stall) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " post_hs_valid"}, W'(out_valid), W'(0));
    check({tag, " post_hs_ready"}, W'(in_ready),  W'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0; out_ready = 1'b0;
    #2;
    check_idle("reset");
    repeat (2) tick();
    rst = 1'b0;
    check_idle("after_reset");

    run_op("nand", 3'd0, 32'hFFFF0000, 32'hFF00FF00, 0);
    check("nand_ref", model(3'd0, 32'hFFFF0000, 32'hFF00FF00), 32'h00FFFFFF);
    run_op("xor_stall", 3'd4, 32'h12345678, 32'hFFFFFFFF, 5);
    run_op("and_zero", 3'd1, 32'hAAAAAAAA, 32'h55555555, 1);
    run_op("rsvd7", 3'd7, 32'hDEADBEEF, 32'hCAFEF00D, 0);
    run_op("rsvd6", 3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);

    // Asynchronous reset in the third RUN cycle aborts the operation.
    in_valid = 1'b1; op = 3'd5; in1 = 32'h0; in2 = 32'h0;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    check_idle("mid_run_reset");
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      check("no_stale_result", W'(out_valid), W'(0));
      tick();
    end
    out_ready = 1'b0;
    run_op("or_after_rst", 3'd2, 32'h0F0F0F0F, 32'hF0F0F0F0, 0);

    for (int k = 0; k < 20; k++) begin
      run_op("random", 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_logic_unit.md
SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter: DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  operand set presented.
REQ-006 Port: in_ready  output  1  unit accepts an operand set.
REQ-007 Port: op  input  3  opcode: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved.
REQ-008 Port: in1, in2  input  WIDTH  operands.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: out1  output  WIDTH  result.
REQ-012 Port: busy  output  1  high in RUN and DONE.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 Acceptance occurs on in_valid&&in_ready: op, in1 and in2 are latched, the digit counter is cleared, and the FSM enters RUN.
REQ-016 RUN: each cycle SHALL compute DIGIT result bits, LSB-first, from the latched operands and the latched op.
REQ-017 Operand and result shift registers SHALL advance by DIGIT bits per cycle.
REQ-018 After WIDTH/DIGIT RUN cycles the FSM SHALL enter DONE with out_valid=1.
REQ-019 Latency from the acceptance edge to out_valid high SHALL be exactly WIDTH/DIGIT cycles.
REQ-020 In DONE, out1 SHALL be stable until out_valid&&out_ready, then the FSM returns to IDLE.
REQ-021 No bypass: a new operand set SHALL be accepted no earlier than the cycle after the result handshake.
REQ-022 Changes on in1, in2 or op during RUN or DONE SHALL have no effect on the result.
REQ-023 Reserved opcodes 6-7 SHALL produce an all-zero result with normal timing.
REQ-024 out1 SHALL be all zeros outside DONE.

Reset
REQ-025 Asserting rst SHALL immediately force the FSM to IDLE and set in_ready=1, out_valid=0, busy=0, out1=0 and the digit counter to 0, in any state, including mid-RUN.
REQ-026 A reset during RUN or DONE SHALL discard the operation in flight; no result is ever emitted for it.
REQ-027 The first acceptance SHALL occur no earlier than the first rising edge after rst deasserts.

Configuration
REQ-028 With SLU_ZERO_FLAG_EN defined, the unit SHALL add output port zero (1 bit).
REQ-029 zero SHALL equal 1 in DONE exactly when out1==0, and 0 otherwise and at reset.
REQ-030 Without SLU_ZERO_FLAG_EN, the zero port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 Package slu_pkg SHALL hold the opcode enum typedef, the FSM state typedef and the WIDTH/DIGIT defaults.
REQ-032 Sub-module slu_digit SHALL be a combinational DIGIT-bit logic cell (op, a, b -> y), instantiated once.

Verification (WIDTH=32, DIGIT=4)
REQ-033 NAND, in1=0xFFFF0000, in2=0xFF00FF00 -> out1=0x00FFFFFF, out_valid exactly 8 cycles after acceptance.
REQ-034 XOR, in1=0x12345678, in2=0xFFFFFFFF, out_ready held 0 for 5 cycles -> out1=0xEDCBA987 stable throughout, in_ready=0 until the cycle after the handshake.
REQ-035 rst pulsed at RUN cycle 3 -> all outputs go to reset values immediately; a following OR 0x0F0F0F0F|0xF0F0F0F0 completes with 0xFFFFFFFF in 8 cycles.
REQ-036 AND, 0xAAAAAAAA & 0x55555555 -> out1=0x00000000; with SLU_ZERO_FLAG_EN, zero=1 in DONE.
REQ-037 op=7 with any operands -> out1=0x00000000 after 8 cycles; in1 toggled during RUN does not alter any result.
